fpu_seq_ctrl: RTL and testbench
===============================

# fpu_seq_ctrl

Multi-cycle FPU sequencer sitting at the M stage, downstream of the EX/MEM register that carries FPUStartE→FPUStartM. It latches operands for an FPU-start instruction, launches the FPU core, stalls the pipeline until the core finishes or times out, and delivers the result, destination register and write pulse toward W. It also handles M-stage flushes mid-operation and accumulates a sticky exception-flag register.

## Interface
- TIMEOUT_CYCLES, 64: maximum WAIT cycles before forced completion (≥2)
- OPW, 3: FPU opcode width
- clk  in  1  pipeline clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- FPUStartM  in  1  M-stage instruction requests an FPU operation
- FPUOpM  in  OPW  opcode
- SrcAM, SrcBM  in  32  operands
- RdM  in  5  destination register
- FPUFlushM  in  1  kill the M-stage instruction (trap/mispredict)
- fpu_start  out  1  one-cycle launch pulse to the FPU core
- fpu_op  out  OPW, fpu_a / fpu_b  out  32  latched operation, stable from ISSUE until return to IDLE
- fpu_done  in  1  one-cycle completion pulse from the core
- fpu_result  in  32, fpu_flags  in  5  valid with fpu_done
- StallFPU  out  1  freeze F/D/E/M stage registers
- FPUWriteW  out  1  one-cycle result-valid pulse
- FPUResultW  out  32, FPURdW  out  5  writeback data/address, held until next write
- FFlags  out  5  sticky OR of completed-op flags
- FFlagsClr  in  1  clear FFlags
- FPUTimeout  out  1  sticky: a timeout has occurred

## Operation
- States: IDLE, ISSUE, WAIT, DONE, ABORT.
- IDLE: FPUStartM && !FPUFlushM → latch op/a/b/rd, go ISSUE. StallFPU asserted combinationally in this cycle.
- ISSUE: fpu_start=1, clear timeout counter, → WAIT; FPUFlushM → ABORT.
- WAIT: counter increments each cycle.
  - fpu_done → capture result/flags, → DONE.
  - counter == TIMEOUT_CYCLES-1 without done → result = 32'h7FC00000 (canonical NaN), flags = NV (bit 4), set FPUTimeout, → DONE.
  - FPUFlushM → ABORT. If it coincides with fpu_done, flush wins → IDLE, no write.
- DONE: FPUWriteW=1, FFlags |= captured flags, StallFPU=0. FPUStartM is ignored in this cycle because the same instruction is leaving M. → IDLE.
- ABORT: wait for fpu_done or timeout (no FPUTimeout set, no write) → IDLE. StallFPU = FPUStartM, so a new FPU op cannot enter while the core drains.
- StallFPU = (IDLE && FPUStartM && !FPUFlushM) | ISSUE | WAIT | (ABORT && FPUStartM).
- fpu_done is sampled only in WAIT and ABORT; it is ignored in IDLE, ISSUE and DONE.
- FFlagsClr has priority as a clear, then the same-cycle DONE OR is applied, so FFlags = new flags.
- Counter width is $clog2(TIMEOUT_CYCLES)+1 and saturates (no wrap).

## Timing
- Reset (async assert, sync-safe deassert): state IDLE; all outputs 0; FFlags=0; FPUTimeout=0; counter=0.
- reset_n low mid-operation: abort immediately, no write. The core is assumed to share the reset.
- FPUStartM seen at cycle 0 → fpu_start at cycle 1 → WAIT from cycle 2.
- fpu_done at cycle k (k≥2) → FPUWriteW and StallFPU low at k+1.
- Minimum latency is 3 cycles, start to write.
- Timeout write lands at cycle TIMEOUT_CYCLES+2.
- Back-to-back FPU instructions: the second is accepted in the IDLE cycle after DONE. Issue rate is at most one op per 4 cycles.

## Structure
- Shared header fpu_defs.vh holds:
  - state encodings
  - FPU opcode values
  - CANON_NAN = 32'h7FC00000
  - flag bit positions NV/DZ/OF/UF/NX = 4..0
- One natural sub-module: fpu_timeout_ctr, a saturating counter with clear, enable and a terminal flag at TIMEOUT_CYCLES-1.

## Test plan
- Basic op: FPUStartM=1, SrcAM=32'h3F800000, SrcBM=32'h40000000, RdM=5; core returns 32'h40400000 with done at cycle 4 → fpu_start at cycle 1, StallFPU high cycles 0–4, FPUWriteW at cycle 5 with FPURdW=5 and FPUResultW=32'h40400000.
- Timeout with TIMEOUT_CYCLES=8 and no done → write at cycle 10, FPUResultW=32'h7FC00000, FFlags=5'b10000, FPUTimeout=1.
- Flush in WAIT at cycle 3, done at cycle 6, and a new FPUStartM at cycle 4:
  - no FPUWriteW for the flushed op;
  - StallFPU stays high through cycle 6;
  - the new op's fpu_start fires at cycle 8.
- Flush and done in the same cycle → return to IDLE next cycle with no write and FFlags unchanged.
- Flags: two ops return flags 5'b00001 then 5'b00100 → FFlags=5'b00101. FFlagsClr asserted in a DONE cycle whose flags are 5'b01000 → FFlags=5'b01000.
- Reset: reset_n low during WAIT → all outputs 0 immediately. After release, a spurious fpu_done in IDLE causes no write.

Source files
------------

// File: rtl/fpu_seq_ctrl_pkg.sv
// Shared definitions for the M-stage FPU sequencer: FSM states, opcodes,
// canonical NaN and exception-flag bit positions.
package fpu_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } fpu_state_e;

  typedef enum logic [2:0] {
    FOP_ADD  = 3'd0,
    FOP_SUB  = 3'd1,
    FOP_MUL  = 3'd2,
    FOP_DIV  = 3'd3,
    FOP_SQRT = 3'd4,
    FOP_MIN  = 3'd5,
    FOP_MAX  = 3'd6,
    FOP_CMP  = 3'd7
  } fpu_op_e;

  typedef enum logic [2:0] {
    FLAG_NX = 3'd0,
    FLAG_UF = 3'd1,
    FLAG_OF = 3'd2,
    FLAG_DZ = 3'd3,
    FLAG_NV = 3'd4
  } fflag_pos_e;

  localparam logic [31:0] CANON_NAN     = 32'h7FC0_0000;
  localparam logic [4:0]  TIMEOUT_FLAGS = 5'b00001 << FLAG_NV;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } fpu_req_t;

endpackage

// File: rtl/fpu_timeout_ctr.sv
// Saturating wait-cycle counter; term flags the last allowed WAIT cycle.
module fpu_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TERM_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  cnt <= '0;
    else if (clr)                  cnt <= '0;
    else if (en && (cnt != '1))    cnt <= cnt + 1'b1;
  end

  assign term = (cnt == TERM_VAL);

endmodule

// File: rtl/fpu_seq_ctrl.sv
// M-stage multi-cycle FPU sequencer: latches an op, launches the core, stalls
// until done/timeout, and hands result + rd to W; drains the core on flush.
module fpu_seq_ctrl
  import fpu_seq_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int OPW            = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            FPUStartM,
  input  logic [OPW-1:0]  FPUOpM,
  input  logic [31:0]     SrcAM,
  input  logic [31:0]     SrcBM,
  input  logic [4:0]      RdM,
  input  logic            FPUFlushM,
  output logic            fpu_start,
  output logic [OPW-1:0]  fpu_op,
  output logic [31:0]     fpu_a,
  output logic [31:0]     fpu_b,
  input  logic            fpu_done,
  input  logic [31:0]     fpu_result,
  input  logic [4:0]      fpu_flags,
  output logic            StallFPU,
  output logic            FPUWriteW,
  output logic [31:0]     FPUResultW,
  output logic [4:0]      FPURdW,
  output logic [4:0]      FFlags,
  input  logic            FFlagsClr,
  output logic            FPUTimeout
);

  fpu_state_e state, nxt;
  fpu_req_t   req;
  logic [4:0] cap_flags;
  logic       latch, capture, to_hit, ctr_clr, ctr_en, term;

  fpu_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .term    (term)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt       = state;
    fpu_start = 1'b0;
    StallFPU  = 1'b0;
    FPUWriteW = 1'b0;
    ctr_clr   = 1'b0;
    ctr_en    = 1'b0;
    latch     = 1'b0;
    capture   = 1'b0;
    to_hit    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (FPUStartM && !FPUFlushM) begin
          latch    = 1'b1;
          StallFPU = 1'b1;
          nxt      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        fpu_start = 1'b1;
        ctr_clr   = 1'b1;
        StallFPU  = 1'b1;
        nxt       = FPUFlushM ? S_ABORT : S_WAIT;
      end
      S_WAIT: begin
        StallFPU = 1'b1;
        ctr_en   = 1'b1;
        // A flush that lands on the core's last cycle has nothing left to drain.
        if (FPUFlushM) begin
          nxt = (fpu_done || term) ? S_IDLE : S_ABORT;
        end else if (fpu_done) begin
          capture = 1'b1;
          nxt     = S_DONE;
        end else if (term) begin
          capture = 1'b1;
          to_hit  = 1'b1;
          nxt     = S_DONE;
        end
      end
      S_DONE: begin
        FPUWriteW = 1'b1;
        nxt       = S_IDLE;
      end
      S_ABORT: begin
        StallFPU = FPUStartM;
        ctr_en   = 1'b1;
        if (fpu_done || term) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fpu_op     <= '0;
      req        <= '0;
      FPUResultW <= '0;
      FPURdW     <= '0;
      cap_flags  <= '0;
      FFlags     <= '0;
      FPUTimeout <= 1'b0;
    end else begin
      if (latch) begin
        fpu_op <= FPUOpM;
        req    <= '{a: SrcAM, b: SrcBM, rd: RdM};
      end
      if (capture) begin
        FPUResultW <= to_hit ? CANON_NAN : fpu_result;
        FPURdW     <= req.rd;
        cap_flags  <= to_hit ? TIMEOUT_FLAGS : fpu_flags;
      end
      if (to_hit) FPUTimeout <= 1'b1;
      // Clear first so a clear in the DONE cycle leaves exactly the new flags.
      FFlags <= (FFlagsClr ? 5'b0 : FFlags) | ((state == S_DONE) ? cap_flags : 5'b0);
    end
  end

  assign fpu_a = req.a;
  assign fpu_b = req.b;

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// Scenario bench for fpu_seq_ctrl: cycle-accurate stall/launch/write checks
// with a scoreboard of expected writebacks.
module tb_fpu_seq_ctrl;
  import fpu_seq_ctrl_pkg::*;

  localparam int TO  = 8;
  localparam int OPW = 3;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            FPUStartM, FPUFlushM, fpu_done, FFlagsClr;
  logic [OPW-1:0]  FPUOpM;
  logic [31:0]     SrcAM, SrcBM, fpu_result;
  logic [4:0]      RdM, fpu_flags;
  logic            fpu_start, StallFPU, FPUWriteW, FPUTimeout;
  logic [OPW-1:0]  fpu_op;
  logic [31:0]     fpu_a, fpu_b, FPUResultW;
  logic [4:0]      FPURdW, FFlags;

  fpu_seq_ctrl #(.TIMEOUT_CYCLES(TO), .OPW(OPW)) dut (
    .clk(clk), .reset_n(reset_n), .FPUStartM(FPUStartM), .FPUOpM(FPUOpM),
    .SrcAM(SrcAM), .SrcBM(SrcBM), .RdM(RdM), .FPUFlushM(FPUFlushM),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_done(fpu_done), .fpu_result(fpu_result), .fpu_flags(fpu_flags),
    .StallFPU(StallFPU), .FPUWriteW(FPUWriteW), .FPUResultW(FPUResultW),
    .FPURdW(FPURdW), .FFlags(FFlags), .FFlagsClr(FFlagsClr), .FPUTimeout(FPUTimeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] res;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [4:0] exp_ff;

  logic            s_start, s_stall, s_wr, s_to;
  logic [OPW-1:0]  s_op;
  logic [31:0]     s_a, s_b, s_res;
  logic [4:0]      s_rd, s_ff;

  // One clock: sample at negedge, score any write, return at posedge+1.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    s_start = fpu_start; s_stall = StallFPU; s_wr = FPUWriteW; s_to = FPUTimeout;
    s_op = fpu_op; s_a = fpu_a; s_b = fpu_b; s_res = FPUResultW; s_rd = FPURdW; s_ff = FFlags;
    if (FPUWriteW) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got rd=%0d res=%h, required no write", FPURdW, FPUResultW);
      end else begin
        e = sb.pop_front();
        if ({FPURdW, FPUResultW} !== {e.rd, e.res}) begin
          miscompares++;
          $display("FAIL write_data: got rd=%0d res=%h, required rd=%0d res=%h",
                   FPURdW, FPUResultW, e.rd, e.res);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    FPUStartM = 1'b0; FPUFlushM = 1'b0; fpu_done = 1'b0; FFlagsClr = 1'b0;
    FPUOpM = '0; SrcAM = '0; SrcBM = '0; RdM = '0;
    fpu_result = 32'hDEAD_BEEF; fpu_flags = 5'b11111;
  endtask

  task automatic check_sb_empty(input string name);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_missing_write: %0d writes outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({fpu_start, fpu_op, fpu_a, fpu_b, StallFPU, FPUWriteW, FPUResultW, FPURdW,
         FFlags, FPUTimeout} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got start=%b stall=%b wr=%b ff=%b to=%b, required all 0",
               fpu_start, StallFPU, FPUWriteW, FFlags, FPUTimeout);
    end
    reset_n = 1'b1;
    tick();
    vectors++;
    if ({s_stall, s_wr, s_start} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_idle: got stall/wr/start=%b%b%b, required 000", s_stall, s_wr, s_start);
    end
    exp_ff = 5'b0;
  endtask

  task automatic test_basic();
    for (int c = 0; c < 8; c++) begin
      FPUStartM = (c <= 5);
      FPUOpM = FOP_ADD; SrcAM = 32'h3F80_0000; SrcBM = 32'h4000_0000; RdM = 5'd5;
      if (c == 0) sb.push_back('{rd: 5'd5, res: 32'h4040_0000});
      fpu_done   = (c == 4);
      fpu_result = (c == 4) ? 32'h4040_0000 : 32'hDEAD_BEEF;
      fpu_flags  = (c == 4) ? 5'b00000 : 5'b11111;
      tick();
      vectors++;
      if ({s_start, s_stall, s_wr} !== {c == 1, c <= 4, c == 5}) begin
        miscompares++;
        $display("FAIL basic_ctrl c%0d: got start/stall/wr=%b%b%b, required %b%b%b",
                 c, s_start, s_stall, s_wr, c == 1, c <= 4, c == 5);
      end
      if (c == 1) begin
        vectors++;
        if ({s_op, s_a, s_b} !== {FOP_ADD, 32'h3F80_0000, 32'h4000_0000}) begin
          miscompares++;
          $display("FAIL basic_operands: got op=%0d a=%h b=%h, required 0 3f800000 40000000",
                   s_op, s_a, s_b);
        end
      end
    end
    idle_inputs();
    vectors++;
    if ({s_rd, s_res, s_ff} !== {5'd5, 32'h4040_0000, exp_ff}) begin
      miscompares++;
      $display("FAIL basic_hold: got rd=%0d res=%h ff=%b, required 5 40400000 %b",
               s_rd, s_res, s_ff, exp_ff);
    end
    check_sb_empty("basic");
  endtask

  task automatic test_timeout();
    for (int c = 0; c < 12; c++) begin
      FPUStartM = (c <= 10);
      FPUOpM = FOP_DIV; SrcAM = 32'h1111_0000; SrcBM = 32'h0; RdM = 5'd7;
      if (c == 0) sb.push_back('{rd: 5'd7, res: 32'h7FC0_0000});
      tick();
      vectors++;
      if ({s_start, s_stall, s_wr} !== {c == 1, c <= TO + 1, c == TO + 2}) begin
        miscompares++;
        $display("FAIL timeout_ctrl c%0d: got start/stall/wr=%b%b%b, required %b%b%b",
                 c, s_start, s_stall, s_wr, c == 1, c <= TO + 1, c == TO + 2);
      end
      if (c == TO + 1 || c == TO + 2) begin
        vectors++;
        if (s_to !== (c == TO + 2)) begin
          miscompares++;
          $display("FAIL timeout_sticky c%0d: got %b, required %b", c, s_to, c == TO + 2);
        end
      end
    end
    exp_ff = exp_ff | 5'b10000;
    vectors++;
    if (s_ff !== exp_ff) begin
      miscompares++;
      $display("FAIL timeout_flags: got %b, required %b", s_ff, exp_ff);
    end
    idle_inputs();
    check_sb_empty("timeout");
  endtask

  task automatic test_flags();
    FFlagsClr = 1'b1;
    tick();
    FFlagsClr = 1'b0;
    exp_ff = 5'b0;
    // back-to-back pair: second op enters M the cycle after the first leaves
    for (int c = 0; c < 9; c++) begin
      FPUStartM = (c <= 7);
      FPUOpM = (c < 4) ? FOP_MUL : FOP_SUB;
      SrcAM = (c < 4) ? 32'hA : 32'hB; SrcBM = 32'h1; RdM = (c < 4) ? 5'd1 : 5'd2;
      if (c == 0) sb.push_back('{rd: 5'd1, res: 32'h1111_1111});
      if (c == 4) sb.push_back('{rd: 5'd2, res: 32'h2222_2222});
      fpu_done   = (c == 2 || c == 6);
      fpu_result = (c == 2) ? 32'h1111_1111 : 32'h2222_2222;
      fpu_flags  = (c == 2) ? 5'b00001 : (c == 6) ? 5'b00100 : 5'b11111;
      tick();
      if (c == 0) begin
        vectors++;
        if (s_ff !== 5'b0) begin
          miscompares++;
          $display("FAIL flags_clear: got %b, required 00000", s_ff);
        end
      end
      vectors++;
      if ({s_start, s_stall, s_wr} !== {c == 1 || c == 5, c <= 2 || (c >= 4 && c <= 6), c == 3 || c == 7}) begin
        miscompares++;
        $display("FAIL b2b_ctrl c%0d: got start/stall/wr=%b%b%b", c, s_start, s_stall, s_wr);
      end
    end
    exp_ff = 5'b00001 | 5'b00100;
    vectors++;
    if (s_ff !== exp_ff) begin
      miscompares++;
      $display("FAIL flags_accum: got %b, required %b", s_ff, exp_ff);
    end
    for (int c = 0; c < 5; c++) begin
      FPUStartM = (c <= 3);
      FPUOpM = FOP_SQRT; SrcAM = 32'hC; SrcBM = 32'h0; RdM = 5'd3;
      if (c == 0) sb.push_back('{rd: 5'd3, res: 32'h3333_3333});
      fpu_done   = (c == 2);
      fpu_result = 32'h3333_3333;
      fpu_flags  = (c == 2) ? 5'b01000 : 5'b11111;
      FFlagsClr  = (c == 3);
      tick();
    end
    exp_ff = 5'b01000;
    vectors++;
    if (s_ff !== exp_ff) begin
      miscompares++;
      $display("FAIL flags_clr_done: got %b, required %b", s_ff, exp_ff);
    end
    idle_inputs();
    check_sb_empty("flags");
  endtask

  task automatic test_flush_wait();
    for (int c = 0; c < 13; c++) begin
      FPUStartM = (c <= 10);
      FPUFlushM = (c == 3);
      FPUOpM = (c < 4) ? FOP_MUL : FOP_MAX;
      SrcAM = (c < 4) ? 32'h5555_0000 : 32'h6666_0000; SrcBM = 32'h2; RdM = (c < 4) ? 5'd10 : 5'd11;
      if (c == 4) sb.push_back('{rd: 5'd11, res: 32'h4120_0000});
      fpu_done   = (c == 6 || c == 10);
      fpu_result = (c == 6) ? 32'hBAD0_0000 : 32'h4120_0000;
      fpu_flags  = (c == 6) ? 5'b00010 : 5'b00000;
      tick();
      vectors++;
      if ({s_start, s_stall, s_wr} !== {c == 1 || c == 8, c <= 10, c == 11}) begin
        miscompares++;
        $display("FAIL flush_wait_ctrl c%0d: got start/stall/wr=%b%b%b, required %b%b%b",
                 c, s_start, s_stall, s_wr, c == 1 || c == 8, c <= 10, c == 11);
      end
      if (c == 8) begin
        vectors++;
        if (s_a !== 32'h6666_0000) begin
          miscompares++;
          $display("FAIL flush_wait_operand: got a=%h, required 66660000", s_a);
        end
      end
    end
    vectors++;
    if (s_ff !== exp_ff) begin
      miscompares++;
      $display("FAIL flush_wait_flags: got %b, required %b", s_ff, exp_ff);
    end
    idle_inputs();
    check_sb_empty("flush_wait");
  endtask

  task automatic test_flush_done();
    for (int c = 0; c < 9; c++) begin
      FPUStartM = (c <= 6);
      FPUFlushM = (c == 3);
      FPUOpM = FOP_CMP;
      SrcAM = (c < 4) ? 32'h7 : 32'h8; SrcBM = 32'h9; RdM = (c < 4) ? 5'd20 : 5'd9;
      if (c == 4) sb.push_back('{rd: 5'd9, res: 32'h0000_0001});
      fpu_done   = (c == 3 || c == 6);
      fpu_result = (c == 3) ? 32'hBAD1_0000 : 32'h0000_0001;
      fpu_flags  = (c == 3) ? 5'b01000 : 5'b00000;
      tick();
      vectors++;
      if ({s_start, s_stall, s_wr} !== {c == 1 || c == 5, c <= 6, c == 7}) begin
        miscompares++;
        $display("FAIL flush_done_ctrl c%0d: got start/stall/wr=%b%b%b, required %b%b%b",
                 c, s_start, s_stall, s_wr, c == 1 || c == 5, c <= 6, c == 7);
      end
    end
    vectors++;
    if (s_ff !== exp_ff) begin
      miscompares++;
      $display("FAIL flush_done_flags: got %b, required %b", s_ff, exp_ff);
    end
    idle_inputs();
    check_sb_empty("flush_done");
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      FPUStartM = 1'b1; FPUOpM = FOP_DIV; SrcAM = 32'hF; SrcBM = 32'hE; RdM = 5'd30;
      tick();
    end
    reset_n = 1'b0;
    FPUStartM = 1'b0;
    #1;
    vectors++;
    if ({fpu_start, fpu_op, fpu_a, fpu_b, StallFPU, FPUWriteW, FPUResultW, FPURdW,
         FFlags, FPUTimeout} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got stall=%b wr=%b a=%h ff=%b to=%b, required all 0",
               StallFPU, FPUWriteW, fpu_a, FFlags, FPUTimeout);
    end
    tick();
    reset_n = 1'b1;
    exp_ff = 5'b0;
    for (int c = 0; c < 4; c++) begin
      fpu_done = (c == 0); fpu_result = 32'hBAD2_0000; fpu_flags = 5'b11111;
      tick();
      vectors++;
      if ({s_stall, s_wr, s_ff} !== {1'b0, 1'b0, exp_ff}) begin
        miscompares++;
        $display("FAIL spurious_done c%0d: got stall=%b wr=%b ff=%b, required 0 0 %b",
                 c, s_stall, s_wr, s_ff, exp_ff);
      end
    end
    idle_inputs();
    check_sb_empty("reset_mid");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_timeout();
    test_flags();
    test_flush_wait();
    test_flush_done();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
